// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with four writeback ports and mispredict flush
module reorder_buffer #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    input  logic [4:0]       alloc_arch_dest_i,
    input  logic [6:0]       alloc_phys_dest_i,
    input  logic [6:0]       alloc_phys_dest_old_i,
    input  logic             alloc_has_dest_i,
    input  logic             alloc_is_fp_i,
    input  logic             alloc_is_vec_i,
    output logic [IDX_W-1:0] alloc_rob_idx_o,
    input  logic             wb0_valid_i,
    input  logic [IDX_W-1:0] wb0_rob_idx_i,
    input  logic [31:0]      wb0_value_i,
    input  logic             wb0_mispredict_i,
    input  logic             wb1_valid_i,
    input  logic [IDX_W-1:0] wb1_rob_idx_i,
    input  logic [31:0]      wb1_value_i,
    input  logic             wb1_mispredict_i,
    input  logic             wb2_valid_i,
    input  logic [IDX_W-1:0] wb2_rob_idx_i,
    input  logic [31:0]      wb2_value_i,
    input  logic             wb2_mispredict_i,
    input  logic             wb3_valid_i,
    input  logic [IDX_W-1:0] wb3_rob_idx_i,
    input  logic [31:0]      wb3_value_i,
    input  logic             wb3_mispredict_i,
    output logic             commit_valid_o,
    output logic [4:0]       commit_arch_dest_o,
    output logic [6:0]       commit_phys_dest_o,
    output logic [6:0]       commit_phys_dest_old_o,
    output logic [31:0]      commit_result_o,
    output logic             commit_is_fp_o,
    output logic             commit_is_vec_o,
    output logic             retire_o,
    output logic             flush_o,
    output logic [IDX_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int NWB = 4;

    logic [IDX_W:0]   head, tail;
    logic [IDX_W-1:0] head_idx, tail_idx;

    logic [DEPTH-1:0] valid, done, mispredict;
    logic [DEPTH-1:0] has_dest, is_fp, is_vec;
    logic [4:0]       arch_dest     [DEPTH];
    logic [6:0]       phys_dest     [DEPTH];
    logic [6:0]       phys_dest_old [DEPTH];
    logic [31:0]      value         [DEPTH];

    logic [NWB-1:0]   wb_valid, wb_mispredict;
    logic [IDX_W-1:0] wb_idx   [NWB];
    logic [31:0]      wb_value [NWB];

    logic [DEPTH-1:0] wb_hit, wb_mis;
    logic [31:0]      wb_val [DEPTH];

    logic retire, flush_now, alloc_fire;

    assign wb_valid      = {wb3_valid_i, wb2_valid_i, wb1_valid_i, wb0_valid_i};
    assign wb_mispredict = {wb3_mispredict_i, wb2_mispredict_i, wb1_mispredict_i, wb0_mispredict_i};
    assign wb_idx[0]     = wb0_rob_idx_i;
    assign wb_idx[1]     = wb1_rob_idx_i;
    assign wb_idx[2]     = wb2_rob_idx_i;
    assign wb_idx[3]     = wb3_rob_idx_i;
    assign wb_value[0]   = wb0_value_i;
    assign wb_value[1]   = wb1_value_i;
    assign wb_value[2]   = wb2_value_i;
    assign wb_value[3]   = wb3_value_i;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    assign empty_o         = (head == tail);
    assign full_o          = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign count_o         = tail - head;
    assign alloc_ready_o   = !full_o && !flush_o;
    assign alloc_rob_idx_o = tail_idx;

    assign retire     = valid[head_idx] && done[head_idx];
    assign flush_now  = retire && mispredict[head_idx];
    assign alloc_fire = alloc_valid_i && alloc_ready_o && !flush_now;

    // Per-entry merge of the writeback ports: ports scanned high to low so the
    // lowest-numbered port that hits an entry supplies its value.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            logic        hit;
            logic        mis;
            logic [31:0] val;
            hit = 1'b0;
            mis = 1'b0;
            val = '0;
            for (int p = NWB - 1; p >= 0; p--) begin
                if (wb_valid[p] && (wb_idx[p] == IDX_W'(e))) begin
                    hit = 1'b1;
                    mis = mis | wb_mispredict[p];
                    val = wb_value[p];
                end
            end
            wb_hit[e] = hit && valid[e] && !flush_now;
            wb_mis[e] = mis;
            wb_val[e] = val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            valid      <= '0;
            done       <= '0;
            mispredict <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wb_hit[e]) begin
                    done[e]       <= 1'b1;
                    mispredict[e] <= mispredict[e] | wb_mis[e];
                end
            end
            if (alloc_fire) begin
                valid[tail_idx]      <= 1'b1;
                done[tail_idx]       <= 1'b0;
                mispredict[tail_idx] <= 1'b0;
                tail                 <= tail + (IDX_W+1)'(1);
            end
            if (retire) begin
                valid[head_idx] <= 1'b0;
                head            <= head + (IDX_W+1)'(1);
            end
            // A mispredicted branch empties the buffer behind itself.
            if (flush_now) begin
                valid <= '0;
                tail  <= head + (IDX_W+1)'(1);
            end
        end
    end

    // Payload storage carries no reset; valid/done gate every use of it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest[tail_idx]      <= alloc_has_dest_i;
            is_fp[tail_idx]         <= alloc_is_fp_i;
            is_vec[tail_idx]        <= alloc_is_vec_i;
            arch_dest[tail_idx]     <= alloc_arch_dest_i;
            phys_dest[tail_idx]     <= alloc_phys_dest_i;
            phys_dest_old[tail_idx] <= alloc_phys_dest_old_i;
        end
        for (int e = 0; e < DEPTH; e++) begin
            if (wb_hit[e]) begin
                value[e] <= wb_val[e];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_o               <= 1'b0;
            flush_o                <= 1'b0;
            commit_valid_o         <= 1'b0;
            commit_arch_dest_o     <= '0;
            commit_phys_dest_o     <= '0;
            commit_phys_dest_old_o <= '0;
            commit_result_o        <= '0;
            commit_is_fp_o         <= 1'b0;
            commit_is_vec_o        <= 1'b0;
        end else begin
            retire_o               <= retire;
            flush_o                <= flush_now;
            commit_valid_o         <= retire && has_dest[head_idx];
            commit_arch_dest_o     <= retire ? arch_dest[head_idx]     : '0;
            commit_phys_dest_o     <= retire ? phys_dest[head_idx]     : '0;
            commit_phys_dest_old_o <= retire ? phys_dest_old[head_idx] : '0;
            commit_result_o        <= retire ? value[head_idx]         : '0;
            commit_is_fp_o         <= retire && is_fp[head_idx];
            commit_is_vec_o        <= retire && is_vec[head_idx];
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core, sitting between the execution writeback buses and the register rename unit. Each renamed instruction is allocated an entry in program order, tagged with its rename results. Entries are marked complete from four writeback ports and retired strictly in order at one per cycle. Retirement drives the rename unit's commit interface and generates the pipeline flush on a mispredicted branch.

## Interface

- `DEPTH`, 32, number of entries; must be a power of two, ≥4.
- `IDX_W`, 5, log2(DEPTH).

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `alloc_valid_i` in 1: allocation request from rename.
- `alloc_ready_o` out 1: entry available; `!full_o && !flush_o`.
- `alloc_arch_dest_i` in 5: architectural destination.
- `alloc_phys_dest_i` in 7: new physical destination.
- `alloc_phys_dest_old_i` in 7: previous mapping.
- `alloc_has_dest_i` in 1: instruction writes a register.
- `alloc_is_fp_i` in 1: FP register class.
- `alloc_is_vec_i` in 1: vector register class.
- `alloc_rob_idx_o` out IDX_W: index being allocated; equals the tail index, combinational.
- `wbN_valid_i` in 1 (N=0..3): writeback strobe.
- `wbN_rob_idx_i` in IDX_W: entry being completed.
- `wbN_value_i` in 32: result.
- `wbN_mispredict_i` in 1: entry is a mispredicted branch.
- `commit_valid_o` out 1: retiring entry has a destination.
- `commit_arch_dest_o` out 5, `commit_phys_dest_o` out 7, `commit_phys_dest_old_o` out 7, `commit_result_o` out 32, `commit_is_fp_o` out 1, `commit_is_vec_o` out 1: fields of the retiring entry.
- `retire_o` out 1: any entry retired (with or without a destination).
- `flush_o` out 1: one-cycle flush pulse to rename and the front end.
- `count_o` out IDX_W+1: occupied entries.
- `full_o` out 1, `empty_o` out 1: occupancy status.

## Operation

- **Per-entry state:** `valid`, `done`, `mispredict`, `has_dest`, `is_fp`, `is_vec`, `arch_dest`, `phys_dest`, `phys_dest_old`, `value[31:0]`.
- **Pointers:** head and tail are IDX_W+1 bits, where the MSB is a wrap bit.
  - `empty` when head == tail.
  - `full` when the indices are equal and the wrap bits differ.
  - `count` = tail − head, modulo 2^(IDX_W+1).
- **Allocate** (`alloc_valid_i && alloc_ready_o`):
  - Write the fields at the tail.
  - Set `valid=1`, `done=0`, `mispredict=0`.
  - Increment tail.
  - Allocation is never accepted when full, even if a retire happens in the same cycle.
- **Writeback:** for each port with `valid` set and the target entry `valid`:
  - Set `done=1`, store `value`, and OR in `mispredict`.
  - Writebacks to invalid entries are ignored.
  - If two or more ports target the same index in one cycle, the lowest-numbered port supplies `value`; `mispredict` is the OR across those ports.
- **Retire:** when the head entry is `valid && done`:
  - Clear `valid` and increment head.
  - Register the fields into the commit outputs and pulse `retire_o`.
  - `commit_valid_o` = `has_dest`. Entries without a destination retire silently, with `commit_valid_o=0`.
- **Flush:** if the retiring entry has `mispredict=1`:
  - The entry itself commits normally.
  - `flush_o=1` in the same cycle as its `commit_valid_o` / `retire_o`.
  - On that edge, every entry's `valid` is cleared and tail is set to the new head, so the buffer becomes empty.
  - Any allocation presented on that edge is discarded; no entry is created and tail does not advance.
  - Writebacks on that edge are discarded.
- **Reset:**
  - head = tail = 0; all `valid`, `done` and `mispredict` cleared.
  - All registered outputs are 0: `commit_*`, `retire_o`, `flush_o`.
  - `count_o`=0, `empty_o`=1, `full_o`=0, `alloc_ready_o`=1, `alloc_rob_idx_o`=0.
  - Reset asserted mid-operation discards all contents immediately.

## Timing

- **Status outputs:** `alloc_ready_o`, `alloc_rob_idx_o`, `count_o`, `full_o` and `empty_o` are combinational from the pointers and the `flush_o` register.
- **Commit outputs** are registered and hold for exactly one cycle per retirement; they are 0 in cycles with no retire.
- **Minimum latency:**
  - Allocation at edge A lets writeback be accepted at edge A+1 at the earliest.
  - Writeback accepted at edge W lets the entry retire at edge W+1, with `commit_valid_o` high during the cycle after W+1.
- **Throughput:** 1 allocation and 1 retirement per cycle. Both can occur on the same edge when neither full nor flushing; `count` is then unchanged.
- **Wrap-around:** indices wrap from DEPTH−1 to 0 with the wrap bit toggling; there are no bubbles at the wrap point.
- **After a flush:** `alloc_ready_o` is low during the `flush_o` cycle. Allocation resumes on the following edge at the index equal to the post-flush head.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream, then release → `empty_o`=1, `count_o`=0, `alloc_rob_idx_o`=0, all `commit_*`/`flush_o`=0.
- **Out-of-order completion:**
  - Allocate 3 entries: idx 0 with arch 5 / phys 40 / old 5, idx 1 with no destination, idx 2 with arch 7 / phys 41 / old 7.
  - Write back idx 2 (value 0xBEEF), then idx 0 (value 0x1234), then idx 1.
  - Required: nothing retires until idx 0 is done. Then, on consecutive cycles, `commit_valid_o`=1 with arch 5 / result 0x1234; then `retire_o`=1 with `commit_valid_o`=0; then arch 7 / result 0xBEEF.
- **Full and wrap-around:**
  - Allocate DEPTH entries → `full_o`=1, `alloc_ready_o`=0, `count_o`=32.
  - Retire one and allocate one; the new entry gets idx 0 after the wrap.
  - Continuous streaming of 100 instructions shows no lost or duplicated commits.
- **Mispredict flush:**
  - Allocate idx 0–4; write back idx 3 and 4 first, then idx 0, then idx 1 with `mispredict`=1.
  - Required: idx 0 commits. Then idx 1 commits with `flush_o`=1 in the same cycle. Then `empty_o`=1, and entries 2–4 never commit.
  - An allocation on the flush edge is dropped.
- **Port conflicts:**
  - wb0 and wb2 target the same idx with values 0xA and 0xB, and only wb2 has `mispredict` set → stored value 0xA, `mispredict`=1.
  - A writeback to an unallocated idx causes no state change.
- **Simultaneous alloc and retire** for 20 cycles at steady occupancy 8 → `count_o` stays at 8 and commits emerge in allocation order.
